cdf_histogram_engine: RTL and testbench
=======================================

Name: cdf_histogram_engine

Overview:
- Frame-level successor to the single-bin cumulative counter.
- Builds a full per-intensity histogram of one frame, with 2**PixelSize bins, in a counter memory.
- On frame end, streams out the cumulative distribution (CDF), one bin per handshake, bin 0 first.
- Feeds the equalization LUT builder. Clears its own memory, so back-to-back frames need no external clear.

Parameters:
PixelSize, 8, pixel bit width; bin count BINS = 2**PixelSize.
FrameWidth, 640, pixels per line; used only to size counters.
FrameHeight, 480, lines per frame; used only to size counters.
histoWidth, $clog2(FrameWidth*FrameHeight+1), width of every bin counter, running sum and cdf_value.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous active-low reset (0 = reset).
pixel_data_in  in  PixelSize  pixel intensity.
pixel_data_valid  in  1  pixel qualifier.
pixel_ready  out  1  engine accepts a pixel this cycle (high only in ACCUM).
frame_end  in  1  single-cycle pulse marking end of frame; honoured only in ACCUM.
cdf_value  out  histoWidth  cumulative count of bins 0..cdf_index.
cdf_index  out  PixelSize  bin currently presented.
cdf_valid  out  1  cdf_value/cdf_index valid.
cdf_ready  in  1  downstream accepts the current CDF beat.
cdf_last  out  1  high with cdf_valid when cdf_index == BINS-1.
busy  out  1  high in every state except ACCUM.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to INIT_CLEAR.
  - pixel_ready=0, cdf_valid=0, cdf_last=0, cdf_value=0, cdf_index=0, busy=1.
  - Pipeline valids cleared. Reset wins over every other event, including mid-SCAN; a partial frame is discarded.
- INIT_CLEAR:
  - Writes zero to bins 0..BINS-1, one bin per cycle, BINS cycles.
  - Then goes to ACCUM.
- ACCUM:
  - pixel_ready=1, busy=0.
  - A pixel is accepted when pixel_data_valid && pixel_ready.
  - Update path is read-modify-write in two stages. Cycle N: read the bin. Cycle N+1: write count+1. The count is visible in memory by N+2.
  - Back-to-back pixels to the same bin, or with one cycle between them, use forwarding from the in-flight write. No increment may be lost at the full input rate of 1 pixel/clk.
  - Bin counters saturate at 2**histoWidth-1; they never wrap.
- frame_end in ACCUM:
  - Go to DRAIN next cycle; pixel_ready drops the cycle after frame_end.
  - A valid pixel in the same cycle as frame_end is counted.
  - frame_end outside ACCUM is ignored.
- DRAIN:
  - 2 cycles, letting in-flight writes retire.
  - Then go to SCAN with index=0 and running sum=0.
- SCAN:
  - Read bin[index], add it to the running sum, present cdf_value = sum, cdf_index = index, cdf_valid=1.
  - First beat is valid no later than 3 cycles after entering SCAN.
  - While cdf_valid && !cdf_ready, all CDF outputs hold stable.
  - On handshake: write zero to bin[index] (clear-on-read), advance index. The next beat may appear on the following cycle; 1 beat/clk is required under continuous ready.
  - Running sum saturates at 2**histoWidth-1.
  - Handshake with cdf_last=1: go to ACCUM. The memory is now all-zero.
- Default wiring: frame pixels ≤ 2**histoWidth-1, so saturation only occurs on over-length frames.

Test Plan:
- Reset held 3 clks then released -> pixel_ready=0 for exactly 256 clks, then 1; busy mirrors it; cdf_valid stays 0.
- Pixels 3,3,3,7 on consecutive clks, then frame_end, cdf_ready=1 -> 256 beats. cdf_value=0 for idx 0..2, 3 for idx 3..6, 4 for idx 7..255; cdf_last only on idx 255.
- cdf_ready toggling 1,0,0,1 during SCAN -> beat held unchanged across the stall; no beat duplicated or skipped; final value 4.
- frame_end coincident with valid pixel value 0 (after pixels 0,0) -> cdf_value at idx 0 is 3.
- Second frame of pixel 255 ×5 immediately after the first scan -> cdf 0 for idx 0..254, 5 at idx 255 (no residue from frame 1).
- FrameWidth=2, FrameHeight=2 (histoWidth=3), nine pixels of value 0 -> idx 0 reports 7 (saturated). rst=0 mid-SCAN -> INIT_CLEAR, and the next frame starts from zero.

Source files
------------

// File: rtl/cdf_histogram_engine.sv
// Frame histogram engine: counts per-intensity occurrences over one frame, then
// streams the cumulative distribution one bin per handshake with clear-on-read.
module cdf_histogram_engine #(
    parameter int PixelSize   = 8,
    parameter int FrameWidth  = 640,
    parameter int FrameHeight = 480,
    parameter int histoWidth  = $clog2(FrameWidth * FrameHeight + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PixelSize-1:0]  pixel_data_in,
    input  logic                  pixel_data_valid,
    output logic                  pixel_ready,
    input  logic                  frame_end,
    output logic [histoWidth-1:0] cdf_value,
    output logic [PixelSize-1:0]  cdf_index,
    output logic                  cdf_valid,
    input  logic                  cdf_ready,
    output logic                  cdf_last,
    output logic                  busy
);
    typedef enum logic [1:0] {INIT_CLEAR, ACCUM, DRAIN, SCAN} state_t;

    function automatic logic [histoWidth-1:0] sat_inc(input logic [histoWidth-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    function automatic logic [histoWidth-1:0] sat_add(input logic [histoWidth-1:0] a,
                                                      input logic [histoWidth-1:0] b);
        logic [histoWidth:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[histoWidth] ? {histoWidth{1'b1}} : s[histoWidth-1:0];
    endfunction

    state_t                state;
    logic [PixelSize-1:0]  clr_idx;
    logic                  drain_cnt;

    logic [histoWidth-1:0] mem [2**PixelSize];
    logic [histoWidth-1:0] rdata;
    logic                  mem_we;
    logic [PixelSize-1:0]  mem_wa;
    logic [PixelSize-1:0]  mem_ra;
    logic [histoWidth-1:0] mem_wd;

    logic                  vld_p1, vld_p2;
    logic [PixelSize-1:0]  addr_p1, addr_p2;
    logic [histoWidth-1:0] cnt_p1, cnt_p2;

    logic [PixelSize-1:0]  scan_ra, fetch_idx;
    logic                  scan_done, fetch_vld;
    logic [histoWidth-1:0] run_sum;

    logic accept, hs, out_free, load_out, issue;

    assign accept   = pixel_data_valid && pixel_ready;
    assign hs       = cdf_valid && cdf_ready;
    assign out_free = !cdf_valid || cdf_ready;
    assign load_out = (state == SCAN) && fetch_vld && out_free;
    // Scan reads run one bin ahead of the output register; on a stall the read
    // address falls back to the held bin so rdata keeps the pending value.
    assign issue    = (state == SCAN) && (!fetch_vld || load_out) && !scan_done;

    // The write retired last cycle is not yet visible to this cycle's read data.
    assign cnt_p1 = sat_inc((vld_p2 && (addr_p2 == addr_p1)) ? cnt_p2 : rdata);

    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_idx;
        mem_wd = '0;
        mem_ra = pixel_data_in;
        case (state)
            INIT_CLEAR: mem_we = 1'b1;
            SCAN: begin
                mem_we = hs;
                mem_wa = cdf_index;
                mem_ra = issue ? scan_ra : fetch_idx;
            end
            default: begin
                mem_we = vld_p1;
                mem_wa = addr_p1;
                mem_wd = cnt_p1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        rdata <= mem[mem_ra];
    end

    // ---- p1: read data returned / increment computed; p2: last written count ----
    always_ff @(posedge clk) begin
        addr_p1 <= pixel_data_in;
        addr_p2 <= addr_p1;
        cnt_p2  <= cnt_p1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= INIT_CLEAR;
            clr_idx     <= '0;
            drain_cnt   <= 1'b0;
            pixel_ready <= 1'b0;
            busy        <= 1'b1;
            cdf_valid   <= 1'b0;
            cdf_last    <= 1'b0;
            cdf_value   <= '0;
            cdf_index   <= '0;
            scan_ra     <= '0;
            scan_done   <= 1'b0;
            fetch_vld   <= 1'b0;
            fetch_idx   <= '0;
            run_sum     <= '0;
        end else begin
            case (state)
                INIT_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (&clr_idx) begin
                        state       <= ACCUM;
                        pixel_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (frame_end) begin
                        state       <= DRAIN;
                        drain_cnt   <= 1'b0;
                        pixel_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state     <= SCAN;
                        scan_ra   <= '0;
                        scan_done <= 1'b0;
                        fetch_vld <= 1'b0;
                        run_sum   <= '0;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        fetch_idx <= scan_ra;
                        scan_ra   <= scan_ra + 1'b1;
                        fetch_vld <= 1'b1;
                        if (&scan_ra) scan_done <= 1'b1;
                    end else if (load_out) begin
                        fetch_vld <= 1'b0;
                    end
                    if (load_out) begin
                        cdf_value <= sat_add(run_sum, rdata);
                        run_sum   <= sat_add(run_sum, rdata);
                        cdf_index <= fetch_idx;
                        cdf_valid <= 1'b1;
                        cdf_last  <= &fetch_idx;
                    end else if (hs) begin
                        cdf_valid <= 1'b0;
                        cdf_last  <= 1'b0;
                    end
                    if (hs && cdf_last) begin
                        state       <= ACCUM;
                        pixel_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= INIT_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_cdf_histogram_engine.sv
// Scoreboard bench: stimulus pushes expected CDF beats, per-DUT monitors pop on handshake.
module tb_cdf_histogram_engine;
    localparam int HW1 = 19;
    localparam int HW2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [7:0]     pd1, pd2;
    logic           pv1, pv2, fe1, fe2, crdy1, crdy2;
    logic           pr1, pr2, cv1, cv2, cl1, cl2, busy1, busy2;
    logic [HW1-1:0] cval1;
    logic [HW2-1:0] cval2;
    logic [7:0]     ci1, ci2;

    cdf_histogram_engine dut1 (
        .clk(clk), .rst(rst), .pixel_data_in(pd1), .pixel_data_valid(pv1),
        .pixel_ready(pr1), .frame_end(fe1), .cdf_value(cval1), .cdf_index(ci1),
        .cdf_valid(cv1), .cdf_ready(crdy1), .cdf_last(cl1), .busy(busy1)
    );

    cdf_histogram_engine #(.PixelSize(8), .FrameWidth(2), .FrameHeight(2)) dut2 (
        .clk(clk), .rst(rst), .pixel_data_in(pd2), .pixel_data_valid(pv2),
        .pixel_ready(pr2), .frame_end(fe2), .cdf_value(cval2), .cdf_index(ci2),
        .cdf_valid(cv2), .cdf_ready(crdy2), .cdf_last(cl2), .busy(busy2)
    );

    typedef struct packed {
        logic        last;
        logic [7:0]  idx;
        logic [31:0] val;
    } beat_t;

    beat_t q1[$];
    beat_t q2[$];
    int hist[256];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (rst && cv1 && crdy1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL cdf1_unexpected_beat: got idx=%0d val=%0d, required no beat", ci1, cval1);
            end else begin
                beat_t b;
                b = q1.pop_front();
                if (ci1 !== b.idx || {13'b0, cval1} !== b.val || cl1 !== b.last) begin
                    errors++;
                    $display("FAIL cdf1_beat: got idx=%0d val=%0d last=%0b, required idx=%0d val=%0d last=%0b",
                             ci1, cval1, cl1, b.idx, b.val, b.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && cv2 && crdy2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL cdf2_unexpected_beat: got idx=%0d val=%0d, required no beat", ci2, cval2);
            end else begin
                beat_t b;
                b = q2.pop_front();
                if (ci2 !== b.idx || {29'b0, cval2} !== b.val || cl2 !== b.last) begin
                    errors++;
                    $display("FAIL cdf2_beat: got idx=%0d val=%0d last=%0b, required idx=%0d val=%0d last=%0b",
                             ci2, cval2, cl2, b.idx, b.val, b.last);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Expected CDF from the hand-set bin counts, clamped to the counter maximum.
    task automatic push_cdf(input int sel, input int maxv);
        int sum;
        beat_t b;
        sum = 0;
        for (int i = 0; i < 256; i++) begin
            sum += hist[i];
            if (sum > maxv) sum = maxv;
            b.last = (i == 255);
            b.idx  = 8'(i);
            b.val  = 32'(sum);
            if (sel == 1) q1.push_back(b); else q2.push_back(b);
            hist[i] = 0;
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic fe);
        @(posedge clk); #1;
        pv1 = 1'b0; pd1 = 8'd0; fe1 = 1'b0;
        pv2 = 1'b0; pd2 = 8'd0; fe2 = 1'b0;
        if (sel == 1) begin pv1 = v; pd1 = d; fe1 = fe; end
        else          begin pv2 = v; pd2 = d; fe2 = fe; end
    endtask

    task automatic run_scan(input int sel, input bit stall, input string name);
        int k;
        bit done;
        done = 0;
        for (k = 0; k < 3000; k++) begin
            if (sel == 1) crdy1 = stall ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            else          crdy2 = 1'b1;
            @(posedge clk); #1;
            if ((sel == 1 && q1.size() == 0) || (sel == 2 && q2.size() == 0)) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_scan_timeout: got %0d beats outstanding, required 0",
                     name, sel == 1 ? q1.size() : q2.size());
            q1.delete();
            q2.delete();
        end
        crdy1 = 1'b0;
        crdy2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_back_to_accum"}, {31'b0, sel == 1 ? pr1 : pr2}, 32'd1);
    endtask

    task automatic wait_ready(input string name, input bit pulse_fe);
        int n;
        bit bad_busy, saw_valid;
        n = 0; bad_busy = 0; saw_valid = 0;
        while (n < 1000) begin
            if (pulse_fe) fe1 = (n == 10);
            @(posedge clk); #1;
            n++;
            if (busy1 !== !pr1) bad_busy = 1;
            if (cv1 !== 1'b0) saw_valid = 1;
            if (pr1 === 1'b1) break;
        end
        fe1 = 1'b0;
        chk({name, "_clear_cycles"}, 32'(n), 32'd256);
        chk({name, "_busy_mirror_err"}, {31'b0, bad_busy}, 32'd0);
        chk({name, "_valid_during_clear"}, {31'b0, saw_valid}, 32'd0);
        chk({name, "_busy_in_accum"}, {31'b0, busy1}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        bit found;
        for (int i = 0; i < 256; i++) hist[i] = 0;
        rst = 1'b0;
        pv1 = 0; pd1 = 0; fe1 = 0; crdy1 = 0;
        pv2 = 0; pd2 = 0; fe2 = 0; crdy2 = 0;

        // Reset held three clocks.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixel_ready", {31'b0, pr1}, 32'd0);
        chk("rst_busy", {31'b0, busy1}, 32'd1);
        chk("rst_cdf_valid", {31'b0, cv1}, 32'd0);
        chk("rst_cdf_last", {31'b0, cl1}, 32'd0);
        chk("rst_cdf_value", {13'b0, cval1}, 32'd0);
        chk("rst_cdf_index", {24'b0, ci1}, 32'd0);
        rst = 1'b1;
        wait_ready("init", 1'b1);
        chk("init_dut2_ready", {31'b0, pr2}, 32'd1);

        // Frame 1: 3,3,3,7 back-to-back.
        hist[3] = 3; hist[7] = 1;
        push_cdf(1, 524287);
        drive(1, 1, 8'd3, 0); drive(1, 1, 8'd3, 0); drive(1, 1, 8'd3, 0);
        drive(1, 1, 8'd7, 0); drive(1, 0, 8'd0, 1); drive(1, 0, 8'd0, 0);
        run_scan(1, 0, "frame1");

        // Same frame with a stalling consumer.
        hist[3] = 3; hist[7] = 1;
        push_cdf(1, 524287);
        drive(1, 1, 8'd3, 0); drive(1, 1, 8'd3, 0); drive(1, 1, 8'd3, 0);
        drive(1, 1, 8'd7, 0); drive(1, 0, 8'd0, 1); drive(1, 0, 8'd0, 0);
        run_scan(1, 1, "stall");

        // Pixel coincident with frame_end is counted.
        hist[0] = 3;
        push_cdf(1, 524287);
        drive(1, 1, 8'd0, 0); drive(1, 1, 8'd0, 0); drive(1, 1, 8'd0, 1);
        drive(1, 0, 8'd0, 0);
        run_scan(1, 0, "fe_coincident");

        // Next frame: no residue left from the previous one.
        hist[255] = 5;
        push_cdf(1, 524287);
        for (int i = 0; i < 5; i++) drive(1, 1, 8'd255, 0);
        drive(1, 0, 8'd0, 1); drive(1, 0, 8'd0, 0);
        run_scan(1, 0, "frame_255");

        // Small frame geometry: 3-bit counters saturate at 7.
        hist[0] = 9;
        push_cdf(2, 7);
        for (int i = 0; i < 9; i++) drive(2, 1, 8'd0, 0);
        drive(2, 0, 8'd0, 1); drive(2, 0, 8'd0, 0);
        run_scan(2, 0, "saturate");

        // Reset in the middle of a scan discards the frame.
        hist[5] = 2;
        push_cdf(1, 524287);
        drive(1, 1, 8'd5, 0); drive(1, 1, 8'd5, 0); drive(1, 0, 8'd0, 1);
        drive(1, 0, 8'd0, 0);
        crdy1 = 1'b0;
        found = 0;
        for (n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (cv1 === 1'b1) begin found = 1; break; end
        end
        chk("midscan_beat_seen", {31'b0, found}, 32'd1);
        chk("midscan_first_value", {13'b0, cval1}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q1.delete();
        chk("midscan_rst_valid", {31'b0, cv1}, 32'd0);
        chk("midscan_rst_ready", {31'b0, pr1}, 32'd0);
        chk("midscan_rst_busy", {31'b0, busy1}, 32'd1);
        chk("midscan_rst_value", {13'b0, cval1}, 32'd0);
        chk("midscan_rst_index", {24'b0, ci1}, 32'd0);
        rst = 1'b1;
        wait_ready("midscan", 1'b0);
        hist[9] = 1;
        push_cdf(1, 524287);
        drive(1, 1, 8'd9, 1); drive(1, 0, 8'd0, 0);
        run_scan(1, 0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
